flash_erase_seq: RTL

SPI NOR erase sequencer driven by the flash state controller. When the controller's `state` bus reads erase (3'd1), the block issues Write-Enable, then the erase command, then polls the status register until the flash reports not-busy. It reports progress on `erasing`, which the controller samples to leave its erase state. The block drives the SPI pins only during its own sequence and runs once per reset.

---
 rtl/flash_pkg.sv | 33 +++
 rtl/spi_byte_xfer.sv | 74 +++++++
 rtl/flash_erase_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash controller and its SPI erase sequencer.
// Controller state codes, SPI NOR opcodes and erase sequencer states.
package flash_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERASE = 3'd1;
  localparam logic [2:0] ST_PROG  = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_CE   = 8'hC7;

  localparam int WIP_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_GAP,
    S_ERASE,
    S_POLL,
    S_CHECK,
    S_DONE
  } seq_t;

  // Chip erase opcodes carry no address; everything else sends 3 address bytes.
  function automatic logic [2:0] erase_len(input logic [7:0] op);
    return (op == OP_CE || op == 8'h60) ? 3'd1 : 3'd4;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// Mode-0 SPI byte shifter, MSB first; back-to-back bytes when start is held.
// done pulses for one cycle as each byte's final SCK fall completes.
module spi_byte_xfer #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        busy;
  logic [15:0] div;
  logic [2:0]  bitn;
  logic [7:0]  sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      div  <= '0;
      bitn <= '0;
      sh   <= '0;
      rx   <= '0;
      done <= 1'b0;
      sck  <= 1'b0;
      mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          sh   <= tx;
          mosi <= tx[7];
          div  <= '0;
          bitn <= '0;
        end
      end else if (div == DIV_LAST) begin
        div <= '0;
        if (!sck) begin
          sck <= 1'b1;
          rx  <= {rx[6:0], miso};
        end else begin
          sck <= 1'b0;
          if (bitn == 3'd7) begin
            done <= 1'b1;
            // A held start chains the next byte with no idle half-bit.
            if (start) begin
              sh   <= tx;
              mosi <= tx[7];
              bitn <= '0;
            end else begin
              busy <= 1'b0;
              mosi <= 1'b0;
            end
          end else begin
            bitn <= bitn + 3'd1;
            sh   <= {sh[6:0], 1'b0};
            mosi <= sh[6];
          end
        end
      end else begin
        div <= div + 16'd1;
      end
    end
  end

endmodule

// File: rtl/flash_erase_seq.sv
// SPI NOR erase sequencer: WREN, erase command, RDSR polling until not busy.
// Optional poll timeout with sticky erase_err when FLASH_ERASE_TIMEOUT_EN is defined.
module flash_erase_seq
  import flash_pkg::*;
#(
  parameter int          CLK_DIV       = 2,
  parameter logic [7:0]  ERASE_OP      = 8'h20,
  parameter logic [23:0] ERASE_ADDR    = 24'h000000,
  parameter int          CS_GAP        = 8,
  parameter logic [19:0] TIMEOUT_POLLS = 20'd1000000
) (
  input  logic       CLK50M,
  input  logic       RST,
  input  logic [2:0] state,
  output logic       erasing,
  output logic       erase_err,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [2:0] ERASE_LEN = erase_len(ERASE_OP);
  localparam logic [7:0] GAP_LAST =
    (CS_GAP > 1) ? 8'(CS_GAP - 1) : 8'd0;

  seq_t       st;
  seq_t       ret;
  logic [1:0] ph;
  logic [2:0] idx;
  logic [2:0] nbytes;
  logic [7:0] gcnt;
  logic       start;
  logic       done;
  logic [7:0] tx;
  logic [7:0] rx;
  logic       unused_rx;

  assign unused_rx = ^rx[7:1];

  always_comb begin
    tx     = 8'h00;
    nbytes = 3'd1;
    case (st)
      S_WREN: tx = OP_WREN;
      S_ERASE: begin
        nbytes = ERASE_LEN;
        case (idx)
          3'd0:    tx = ERASE_OP;
          3'd1:    tx = ERASE_ADDR[23:16];
          3'd2:    tx = ERASE_ADDR[15:8];
          default: tx = ERASE_ADDR[7:0];
        endcase
      end
      S_POLL: begin
        nbytes = 3'd2;
        tx     = (idx == 3'd0) ? OP_RDSR : 8'h00;
      end
      default: ;
    endcase
  end

  spi_byte_xfer #(
    .CLK_DIV(CLK_DIV)
  ) u_xfer (
    .clk  (CLK50M),
    .rst_n(RST),
    .start(start),
    .tx   (tx),
    .rx   (rx),
    .done (done),
    .sck  (spi_sck),
    .mosi (spi_mosi),
    .miso (spi_miso)
  );

`ifdef FLASH_ERASE_TIMEOUT_EN
  logic [19:0] polls;
`else
  logic [19:0] unused_tmo;
  assign unused_tmo = TIMEOUT_POLLS;
  assign erase_err  = 1'b0;
`endif

  always_ff @(posedge CLK50M) begin
    if (!RST) begin
      st       <= S_IDLE;
      ret      <= S_ERASE;
      ph       <= '0;
      idx      <= '0;
      gcnt     <= '0;
      start    <= 1'b0;
      spi_cs_n <= 1'b1;
      erasing  <= 1'b1;
`ifdef FLASH_ERASE_TIMEOUT_EN
      polls     <= '0;
      erase_err <= 1'b0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (state == ST_ERASE) begin
            st <= S_WREN;
            ph <= '0;
          end
        end
        S_WREN, S_ERASE, S_POLL: begin
          // ph: settle, drop CS + start, byte 0 accepted, run.
          case (ph)
            2'd0: ph <= 2'd1;
            2'd1: begin
              spi_cs_n <= 1'b0;
              start    <= 1'b1;
              idx      <= '0;
              ph       <= 2'd2;
            end
            2'd2: begin
              idx   <= 3'd1;
              start <= (nbytes > 3'd1);
              ph    <= 2'd3;
            end
            default: begin
              if (done) begin
                if (idx == nbytes) begin
                  spi_cs_n <= 1'b1;
                  gcnt     <= '0;
                  if (st == S_POLL) begin
                    st <= S_CHECK;
                  end else begin
                    st  <= S_GAP;
                    ret <= (st == S_WREN) ? S_ERASE : S_POLL;
                  end
                end else begin
                  idx   <= idx + 3'd1;
                  start <= (idx + 3'd1 != nbytes);
                end
              end
            end
          endcase
        end
        S_GAP: begin
          if (gcnt >= GAP_LAST) begin
            st <= ret;
            ph <= '0;
          end else begin
            gcnt <= gcnt + 8'd1;
          end
        end
        S_CHECK: begin
`ifdef FLASH_ERASE_TIMEOUT_EN
          polls <= polls + 20'd1;
          if (!rx[WIP_BIT]) begin
            st      <= S_DONE;
            erasing <= 1'b0;
          end else if (polls + 20'd1 >= TIMEOUT_POLLS) begin
            st        <= S_DONE;
            erasing   <= 1'b0;
            erase_err <= 1'b1;
          end else begin
            st  <= S_GAP;
            ret <= S_POLL;
          end
`else
          if (!rx[WIP_BIT]) begin
            st      <= S_DONE;
            erasing <= 1'b0;
          end else begin
            st  <= S_GAP;
            ret <= S_POLL;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
